// File: rtl/axi_brom_rd_ctrl.sv
// AXI4 read-only slave sequencing a single-port BRAM/ROM: one burst at a time,
// FIXED/INCR/WRAP address generation, 2-entry credit-managed read-data buffer.
module axi_brom_rd_ctrl #(
  parameter int MEM_DATA_WIDTH  = 128,
  parameter int BRAM_ADDR_WIDTH = 16,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_ID_WIDTH    = 4
) (
  input  logic                          clka,
  input  logic                          rsta_n,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_arid,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [MEM_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_rid,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic [BRAM_ADDR_WIDTH-1:0]    bram_addra,
  output logic                          bram_ena,
  output logic [MEM_DATA_WIDTH/8-1:0]   bram_wea,
  output logic [MEM_DATA_WIDTH-1:0]     bram_dina,
  input  logic [MEM_DATA_WIDTH-1:0]     bram_douta
);

  localparam int AW         = BRAM_ADDR_WIDTH;
  localparam int LINE_BYTES = MEM_DATA_WIDTH / 8;

  typedef enum logic {S_IDLE, S_BURST} state_e;
  typedef enum logic [1:0] {MODE_FIXED, MODE_INCR, MODE_WRAP} mode_e;

  state_e                      state_q, state_d;
  mode_e                       mode_q, mode_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [AW-1:0]               step_q, step_d;
  logic [AW-1:0]               wrap_mask_q, wrap_mask_d;
  logic [AXI_ID_WIDTH-1:0]     id_q, id_d;
  logic [8:0]                  issue_cnt_q, issue_cnt_d;
  logic [8:0]                  ret_cnt_q, ret_cnt_d;
  logic                        inflight_q, inflight_d;
  logic [MEM_DATA_WIDTH-1:0]   buf_q [2];
  logic [MEM_DATA_WIDTH-1:0]   buf_d [2];
  logic                        head_q, head_d;
  logic                        tail_q, tail_d;
  logic [1:0]                  count_q, count_d;

  logic          ar_hs, pop, issue;
  logic [2:0]    occ;
  logic [AW-1:0] incr_addr, next_addr;
  logic          unused_araddr;

  assign unused_araddr = ^s_axi_araddr[AXI_ADDR_WIDTH-1:AW];

  assign s_axi_arready = rsta_n && (state_q == S_IDLE);
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign s_axi_rvalid  = (count_q != 2'd0);
  assign pop           = s_axi_rvalid && s_axi_rready;

  // Credits: buffered beats plus the beat arriving from the BRAM, net of this cycle's pop.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = rsta_n && (state_q == S_BURST) && (issue_cnt_q != 9'd0) && (occ < 3'd2);

  assign incr_addr = addr_q + step_q;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    next_addr = incr_addr;
    case (mode_q)
      MODE_FIXED: next_addr = addr_q;
      MODE_WRAP:  next_addr = (addr_q & ~wrap_mask_q) | (incr_addr & wrap_mask_q);
      default:    next_addr = incr_addr;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    step_d      = step_q;
    wrap_mask_d = wrap_mask_q;
    id_d        = id_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    inflight_d  = issue;
    buf_d       = buf_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q + {1'b0, inflight_q} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          state_d     = S_BURST;
          addr_d      = s_axi_araddr[AW-1:0];
          id_d        = s_axi_arid;
          step_d      = AW'(1) << s_axi_arsize;
          wrap_mask_d = ((AW'(s_axi_arlen) + AW'(1)) << s_axi_arsize) - AW'(1);
          issue_cnt_d = {1'b0, s_axi_arlen} + 9'd1;
          ret_cnt_d   = {1'b0, s_axi_arlen} + 9'd1;
          case (s_axi_arburst)
            2'b00:   mode_d = MODE_FIXED;
            2'b10:   mode_d = (s_axi_arlen == 8'd1 || s_axi_arlen == 8'd3 ||
                               s_axi_arlen == 8'd7 || s_axi_arlen == 8'd15) ? MODE_WRAP : MODE_INCR;
            default: mode_d = MODE_INCR;
          endcase
        end
      end
      S_BURST: begin
        if (issue) begin
          addr_d      = next_addr;
          issue_cnt_d = issue_cnt_q - 9'd1;
        end
        if (pop) begin
          ret_cnt_d = ret_cnt_q - 9'd1;
          if (ret_cnt_q == 9'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (inflight_q) begin
      buf_d[tail_q] = bram_douta;
      tail_d        = ~tail_q;
    end
    if (pop) head_d = ~head_q;
  end

  always_ff @(posedge clka) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    if (!rsta_n) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_FIXED;
      addr_q      <= '0;
      step_q      <= '0;
      wrap_mask_q <= '0;
      id_q        <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      // NOTE: the two buffer entries are reset so RDATA reads 0 out of reset; larger memories normally would not be.
      buf_q       <= '{default: '0};
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      step_q      <= step_d;
      wrap_mask_q <= wrap_mask_d;
      id_q        <= id_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      inflight_q  <= inflight_d;
      buf_q       <= buf_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  assign s_axi_rdata = buf_q[head_q];
  assign s_axi_rid   = id_q;
  assign s_axi_rresp = 2'b00;
  assign s_axi_rlast = (ret_cnt_q == 9'd1);

  assign bram_ena   = issue;
  assign bram_addra = addr_q & ~AW'(LINE_BYTES - 1);
  assign bram_wea   = '0;
  assign bram_dina  = '0;

endmodule
